// File: rtl/mul_scheduler.sv
// mul_scheduler: sequences the iterative multiplier and the HI/LO accumulator
// in the execute stage. It accepts multiply-class ops, starts the multiplier
// with the latched sign and accumulate mode, and counts down the multiplier
// latency. It pulses the HI/LO write (or the GPR result strobe for MUL) on
// completion. It also raises the pipeline Stall for HI/LO hazards and while
// a GPR-destination MUL result is pending.
module mul_scheduler #(
   parameter int MUL_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       IssueValid,
   input  logic       ALUOp,
   input  logic       MULOp,
   input  logic [5:0] Func,
   output logic       Stall,
   output logic       Busy,
   output logic       MulStart,
   output logic       MulSigned,
   output logic [1:0] AccMode,
   output logic       ACCEn,
   output logic       ResultValid
);

   localparam int CW = $clog2(MUL_CYCLES) + 1;
   localparam logic [CW-1:0] CountLoad = CW'(MUL_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t        state_q;
   logic [CW-1:0] count_q;
   logic          mulStart_q;
   logic          mulSigned_q;
   logic [1:0]    accMode_q;
   logic          gpr_q;

   logic          unitOp;
   logic          hiloOp;
   logic          opSigned_d;
   logic [1:0]    opMode_d;
   logic          busyNow;
   logic          done;
   logic          accept;

   // Decode the presented instruction into unit op / HI/LO op and the fields
   // to latch. ALUOp decode wins if both class flags are (illegally) high.
   always_comb begin
      unitOp     = 1'b0;
      hiloOp     = 1'b0;
      opSigned_d = 1'b0;
      opMode_d   = 2'b11;
      if (ALUOp) begin
         case (Func)
            6'h18: begin unitOp = 1'b1; opSigned_d = 1'b1; opMode_d = 2'b00; end
            6'h19: begin unitOp = 1'b1; opSigned_d = 1'b0; opMode_d = 2'b00; end
            6'h10, 6'h11, 6'h12, 6'h13: hiloOp = 1'b1;
            default: ;
         endcase
      end else if (MULOp) begin
         case (Func)
            6'h00: begin unitOp = 1'b1; opSigned_d = 1'b1; opMode_d = 2'b01; end
            6'h01: begin unitOp = 1'b1; opSigned_d = 1'b0; opMode_d = 2'b01; end
            6'h04: begin unitOp = 1'b1; opSigned_d = 1'b1; opMode_d = 2'b10; end
            6'h05: begin unitOp = 1'b1; opSigned_d = 1'b0; opMode_d = 2'b10; end
            6'h02: begin unitOp = 1'b1; opSigned_d = 1'b1; opMode_d = 2'b11; end
            default: ;
         endcase
      end
   end

   // Hazard detection and completion. HI/LO ops wait through the done cycle
   // because HI/LO is only written at the end of it; a new unit op may slip in
   // on the done cycle to keep the multiplier back-to-back.
   always_comb begin
      busyNow     = (state_q == BUSY);
      done        = busyNow && (count_q == '0);
      Stall       = (busyNow && gpr_q && !done)
                 || (IssueValid && hiloOp && busyNow)
                 || (IssueValid && unitOp && busyNow && !done);
      accept      = IssueValid && unitOp && !Stall;
      ACCEn       = done && (accMode_q != 2'b11);
      ResultValid = done && gpr_q;
   end

   // Scheduler FSM: latch the op on accept, count down the latency, and
   // return to IDLE on completion unless a new op is accepted that cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         mulStart_q  <= 1'b0;
         mulSigned_q <= 1'b0;
         accMode_q   <= 2'b11;
         gpr_q       <= 1'b0;
      end else if (accept) begin
         state_q     <= BUSY;
         count_q     <= CountLoad;
         mulStart_q  <= 1'b1;
         mulSigned_q <= opSigned_d;
         accMode_q   <= opMode_d;
         gpr_q       <= (opMode_d == 2'b11);
      end else begin
         mulStart_q <= 1'b0;
         if (state_q == BUSY) begin
            if (count_q == '0) begin
               state_q <= IDLE;
            end else begin
               count_q <= count_q - 1'b1;
            end
         end
      end
   end

   // Registered status outputs straight from the FSM state.
   always_comb begin
      Busy      = busyNow;
      MulStart  = mulStart_q;
      MulSigned = mulSigned_q;
      AccMode   = accMode_q;
   end

endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed-vector bench for mul_scheduler. One instance uses
// a 4-cycle multiplier and one a 1-cycle multiplier; both share the inputs.
// Each cycle the outputs are packed as
// {Stall, Busy, MulStart, MulSigned, AccMode[1:0], ACCEn, ResultValid}
// and compared with a hand-computed constant.
module tb_mul_scheduler;

   logic       clock;
   logic       reset;
   logic       IssueValid;
   logic       ALUOp;
   logic       MULOp;
   logic [5:0] Func;

   logic       stall4, busy4, mulStart4, mulSigned4, accEn4, resultValid4;
   logic [1:0] accMode4;
   logic       stall1, busy1, mulStart1, mulSigned1, accEn1, resultValid1;
   logic [1:0] accMode1;

   int errors = 0;
   int checks = 0;

   mul_scheduler #(.MUL_CYCLES(4)) dut4 (
      .clock(clock), .reset(reset), .IssueValid(IssueValid), .ALUOp(ALUOp),
      .MULOp(MULOp), .Func(Func), .Stall(stall4), .Busy(busy4),
      .MulStart(mulStart4), .MulSigned(mulSigned4), .AccMode(accMode4),
      .ACCEn(accEn4), .ResultValid(resultValid4)
   );

   mul_scheduler #(.MUL_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset), .IssueValid(IssueValid), .ALUOp(ALUOp),
      .MULOp(MULOp), .Func(Func), .Stall(stall1), .Busy(busy1),
      .MulStart(mulStart1), .MulSigned(mulSigned1), .AccMode(accMode1),
      .ACCEn(accEn1), .ResultValid(resultValid1)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] outs4();
      return {stall4, busy4, mulStart4, mulSigned4, accMode4, accEn4, resultValid4};
   endfunction

   function automatic logic [7:0] outs1();
      return {stall1, busy1, mulStart1, mulSigned1, accMode1, accEn1, resultValid1};
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic alu, input logic mul,
                                input logic [5:0] func);
      IssueValid = iv;
      ALUOp      = alu;
      MULOp      = mul;
      Func       = func;
   endtask

   // Drive one cycle's inputs (just after the rising edge), check the chosen
   // instance on the falling edge, then advance past the next rising edge.
   task automatic runCycle(input logic iv, input logic alu, input logic mul,
                           input logic [5:0] func, input bit useDut1,
                           input logic [7:0] expected, input string tag);
      applyStimulus(iv, alu, mul, func);
      @(negedge clock);
      checkOutput(tag, useDut1 ? outs1() : outs4(), expected);
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 6'h00);
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("reset4", outs4(), 8'h0C);
      checkOutput("reset1", outs1(), 8'h0C);
      reset = 1'b0;

      // MULT, then idle; a unit op without IssueValid is ignored.
      runCycle(1, 1, 0, 6'h18, 0, 8'h0C, "mult c0");
      runCycle(0, 0, 0, 6'h00, 0, 8'h70, "mult c1");
      runCycle(0, 0, 0, 6'h00, 0, 8'h50, "mult c2");
      runCycle(0, 0, 0, 6'h00, 0, 8'h50, "mult c3");
      runCycle(0, 0, 0, 6'h00, 0, 8'h52, "mult c4");
      runCycle(0, 1, 0, 6'h18, 0, 8'h10, "mult c5 noIssue");
      runCycle(0, 0, 0, 6'h00, 0, 8'h10, "mult c6 noIssue");

      // MADDU with MFHI behind it: MFHI stalls through the done cycle.
      runCycle(1, 0, 1, 6'h01, 0, 8'h10, "maddu c0");
      runCycle(0, 0, 0, 6'h00, 0, 8'h64, "maddu c1");
      runCycle(1, 1, 0, 6'h10, 0, 8'hC4, "maddu c2 mfhi");
      runCycle(1, 1, 0, 6'h10, 0, 8'hC4, "maddu c3 mfhi");
      runCycle(1, 1, 0, 6'h10, 0, 8'hC6, "maddu c4 mfhi");
      runCycle(1, 1, 0, 6'h10, 0, 8'h04, "maddu c5 mfhi");
      runCycle(0, 0, 0, 6'h00, 0, 8'h04, "maddu c6");

      // MUL with an unrelated ALU op behind it: GPR-pending stall.
      runCycle(1, 0, 1, 6'h02, 0, 8'h04, "mul c0");
      runCycle(1, 1, 0, 6'h20, 0, 8'hFC, "mul c1");
      runCycle(1, 1, 0, 6'h20, 0, 8'hDC, "mul c2");
      runCycle(1, 1, 0, 6'h20, 0, 8'hDC, "mul c3");
      runCycle(1, 1, 0, 6'h20, 0, 8'h5D, "mul c4");
      runCycle(0, 0, 0, 6'h00, 0, 8'h1C, "mul c5");

      // MSUB with MULTU back-to-back on the done cycle.
      runCycle(1, 0, 1, 6'h04, 0, 8'h1C, "msub c0");
      runCycle(0, 0, 0, 6'h00, 0, 8'h78, "msub c1");
      runCycle(1, 1, 0, 6'h19, 0, 8'hD8, "msub c2");
      runCycle(1, 1, 0, 6'h19, 0, 8'hD8, "msub c3");
      runCycle(1, 1, 0, 6'h19, 0, 8'h5A, "msub c4");
      runCycle(0, 0, 0, 6'h00, 0, 8'h60, "multu c5");
      runCycle(0, 0, 0, 6'h00, 0, 8'h40, "multu c6");
      runCycle(0, 0, 0, 6'h00, 0, 8'h40, "multu c7");
      runCycle(0, 0, 0, 6'h00, 0, 8'h42, "multu c8");
      runCycle(0, 0, 0, 6'h00, 0, 8'h00, "multu c9");

      // MULT interrupted by an asynchronous mid-cycle reset.
      runCycle(1, 1, 0, 6'h18, 0, 8'h00, "rst c0");
      runCycle(0, 0, 0, 6'h00, 0, 8'h70, "rst c1");
      applyStimulus(0, 0, 0, 6'h00);
      @(negedge clock);
      checkOutput("rst c2 before", outs4(), 8'h50);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst c2 async", outs4(), 8'h0C);
      @(posedge clock);
      #1;
      reset = 1'b0;
      runCycle(0, 0, 0, 6'h00, 0, 8'h0C, "rst c3");
      runCycle(1, 1, 0, 6'h18, 0, 8'h0C, "rst c4 noAcc");
      runCycle(0, 0, 0, 6'h00, 0, 8'h70, "rst c5");
      runCycle(0, 0, 0, 6'h00, 0, 8'h50, "rst c6");
      runCycle(0, 0, 0, 6'h00, 0, 8'h50, "rst c7");
      runCycle(0, 0, 0, 6'h00, 0, 8'h52, "rst c8");
      runCycle(0, 0, 0, 6'h00, 0, 8'h10, "rst c9");

      // Single-cycle multiplier: MulStart and ACCEn coincide; CLZ is ignored.
      runCycle(1, 0, 1, 6'h00, 1, 8'h10, "one c0");
      runCycle(0, 0, 0, 6'h00, 1, 8'h76, "one c1");
      runCycle(1, 0, 1, 6'h20, 1, 8'h14, "one c2 clz");
      runCycle(1, 0, 1, 6'h20, 1, 8'h14, "one c3 clz");
      runCycle(0, 0, 0, 6'h00, 1, 8'h14, "one c4");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
